// File: rtl/fpga_clk_ctrl.sv
// Multi-channel divided CPU clock generator with glitch-free run/halt/single-step control
// and a debounced step push-button.
module fpga_clk_ctrl #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned DEFAULT_DIV = 100000000,
  parameter int unsigned DB_CYCLES   = 1000000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [1:0]        MODE,
  input  logic [NUM_CH-1:0] DIV_WE,
  input  logic [CNT_W-1:0]  DIV_VALUE,
  input  logic              STEP_BTN,
  output logic [NUM_CH-1:0] CPU_CLK,
  output logic [NUM_CH-1:0] CPU_TICK,
  output logic              STEP_ACK,
  output logic              HALTED
);

  localparam int unsigned     DB_W    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

  typedef enum logic [1:0] {StParked, StRunning, StParking, StStepping} ch_state_e;

  ch_state_e         r_st       [NUM_CH];
  logic [CNT_W-1:0]  r_cnt      [NUM_CH];
  logic [CNT_W-1:0]  r_div      [NUM_CH];
  logic [CNT_W-1:0]  r_shadow   [NUM_CH];
  logic [CNT_W-1:0]  w_shadow_nxt [NUM_CH];
  logic [NUM_CH-1:0] r_clk, r_tick;
  logic [NUM_CH-1:0] w_parked, w_tc, w_count;

  logic [1:0]      r_sync;
  logic            r_db_level;
  logic [DB_W-1:0] r_db_cnt;
  logic            r_step_req, r_step_busy, r_step_ack;

  logic w_run, w_all_parked, w_step_go;

  assign w_run        = (MODE == 2'b00);
  assign w_all_parked = &w_parked;
  assign w_step_go    = r_step_req && (MODE == 2'b10) && !r_step_busy && w_all_parked;

  always_comb begin
    w_parked = '0;
    w_tc     = '0;
    w_count  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_parked[i]     = (r_st[i] == StParked);
      w_tc[i]         = (r_cnt[i] == r_div[i]);
      w_shadow_nxt[i] = DIV_WE[i] ? DIV_VALUE : r_shadow[i];
      // A running channel leaving RUN while low parks at once instead of counting on.
      w_count[i]      = (r_st[i] == StParking) || (r_st[i] == StStepping) ||
                        ((r_st[i] == StRunning) && (w_run || r_clk[i]));
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_clk  <= '0;
      r_tick <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_st[i]     <= StParked;
        r_cnt[i]    <= '0;
        r_div[i]    <= DIV_RST;
        r_shadow[i] <= DIV_RST;
      end
    end else begin
      r_tick <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        if (DIV_WE[i]) r_shadow[i] <= DIV_VALUE;
        if (w_count[i]) begin
          if (w_tc[i]) begin
            r_cnt[i]  <= '0;
            r_clk[i]  <= ~r_clk[i];
            r_tick[i] <= ~r_clk[i];
            r_div[i]  <= w_shadow_nxt[i];
          end else begin
            r_cnt[i] <= r_cnt[i] + CNT_W'(1);
          end
        end
        case (r_st[i])
          StParked: begin
            r_cnt[i] <= '0;
            r_clk[i] <= 1'b0;
            r_div[i] <= w_shadow_nxt[i];
            if (w_run)          r_st[i] <= StRunning;
            else if (w_step_go) r_st[i] <= StStepping;
          end
          StRunning: begin
            if (!w_run) begin
              if (!r_clk[i]) begin
                r_st[i]  <= StParked;
                r_cnt[i] <= '0;
              end else if (w_tc[i]) begin
                r_st[i] <= StParked;
              end else begin
                r_st[i] <= StParking;
              end
            end
          end
          StParking: begin
            if (w_run)        r_st[i] <= StRunning;
            else if (w_tc[i]) r_st[i] <= StParked;
          end
          StStepping: begin
            if (w_tc[i] && r_clk[i]) r_st[i] <= StParked;
          end
          default: r_st[i] <= StParked;
        endcase
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sync      <= '0;
      r_db_level  <= 1'b0;
      r_db_cnt    <= '0;
      r_step_req  <= 1'b0;
      r_step_busy <= 1'b0;
      r_step_ack  <= 1'b0;
    end else begin
      r_sync     <= {r_sync[0], STEP_BTN};
      r_step_req <= 1'b0;
      r_step_ack <= 1'b0;
      if (r_sync[1] != r_db_level) begin
        if (r_db_cnt == DB_LAST) begin
          r_db_level <= r_sync[1];
          r_db_cnt   <= '0;
          r_step_req <= r_sync[1];
        end else begin
          r_db_cnt <= r_db_cnt + DB_W'(1);
        end
      end else begin
        r_db_cnt <= '0;
      end
      if (w_step_go) begin
        r_step_busy <= 1'b1;
      end else if (r_step_busy && w_all_parked) begin
        r_step_busy <= 1'b0;
        r_step_ack  <= 1'b1;
      end
    end
  end

  assign CPU_CLK  = r_clk;
  assign CPU_TICK = r_tick;
  assign STEP_ACK = r_step_ack;
  assign HALTED   = w_all_parked;

endmodule

// File: tb/tb_fpga_clk_ctrl.sv
// Directed bench for fpga_clk_ctrl: reset, run waveforms, halt, debounced step,
// divider reload and reset during a step.
module tb_fpga_clk_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [1:0]  MODE = 2'b00;
  logic [1:0]  DIV_WE = 2'b00;
  logic [15:0] DIV_VALUE = '0;
  logic        STEP_BTN = 1'b0;
  logic [1:0]  CPU_CLK, CPU_TICK;
  logic        STEP_ACK, HALTED;

  int checks = 0;
  int failures = 0;

  int rises [2] = '{0, 0};
  int ticks [2] = '{0, 0};
  int acks = 0;
  int tick_bad = 0;
  logic [1:0] prev_clk = 2'b00;

  fpga_clk_ctrl #(
    .CNT_W(16), .NUM_CH(2), .DEFAULT_DIV(5), .DB_CYCLES(4)
  ) dut (
    .CLK(CLK), .RST(RST), .MODE(MODE), .DIV_WE(DIV_WE), .DIV_VALUE(DIV_VALUE),
    .STEP_BTN(STEP_BTN), .CPU_CLK(CPU_CLK), .CPU_TICK(CPU_TICK), .STEP_ACK(STEP_ACK),
    .HALTED(HALTED)
  );

  always #5 CLK = ~CLK;

  // Edge/tick bookkeeping sampled mid-cycle.
  always @(negedge CLK) begin
    for (int i = 0; i < 2; i++) begin
      if (CPU_CLK[i] && !prev_clk[i]) rises[i]++;
      if (CPU_TICK[i]) ticks[i]++;
      if (!RST && (CPU_TICK[i] !== (CPU_CLK[i] && !prev_clk[i]))) tick_bad++;
    end
    if (STEP_ACK) acks++;
    prev_clk = CPU_CLK;
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_tick0(input int max_cycles, input string tag);
    int n = 0;
    while (!CPU_TICK[0] && n < max_cycles) begin
      step();
      n++;
    end
    chk(tag, {31'd0, CPU_TICK[0]}, 32'd1);
  endtask

  task automatic wait_halted(input int max_cycles, input string tag);
    int n = 0;
    while (!HALTED && n < max_cycles) begin
      step();
      n++;
    end
    chk(tag, {31'd0, HALTED}, 32'd1);
  endtask

  initial begin
    int r0, r1, t0, t1, a0;
    logic [3:0] exp_w;
    logic [9:0] reload_exp;

    // Reset held 2 cycles with MODE=RUN.
    step();
    step();
    chk("rst_clk", {30'd0, CPU_CLK}, 32'd0);
    chk("rst_tick", {30'd0, CPU_TICK}, 32'd0);
    chk("rst_halted", {31'd0, HALTED}, 32'd1);
    chk("rst_ack", {31'd0, STEP_ACK}, 32'd0);
    RST = 1'b0;
    step();
    chk("rel_halted", {31'd0, HALTED}, 32'd0);

    // Park and program ch0=3, ch1=0.
    MODE = 2'b01;
    DIV_WE = 2'b01;
    DIV_VALUE = 16'd3;
    step();
    DIV_WE = 2'b10;
    DIV_VALUE = 16'd0;
    step();
    DIV_WE = 2'b00;
    step();
    chk("parked_halted", {31'd0, HALTED}, 32'd1);

    // 64-cycle run waveform: ch0 period 8 starting 4 cycles after RUNNING, ch1 period 2.
    MODE = 2'b00;
    for (int k = 1; k <= 64; k++) begin
      step();
      exp_w[0] = (k >= 5) && (((k - 5) / 4) % 2 == 0);
      exp_w[1] = (k >= 2) && ((k - 2) % 2 == 0);
      exp_w[2] = (k >= 5) && ((k - 5) % 8 == 0);
      exp_w[3] = (k >= 2) && ((k - 2) % 2 == 0);
      chk("run_wave", {28'd0, CPU_TICK, CPU_CLK}, {28'd0, exp_w});
    end
    chk("run_tick_bad", tick_bad, 0);

    // HALT the cycle after a ch0 rising edge: high phase still lasts 4 cycles.
    wait_tick0(20, "halt_wait_rise");
    MODE = 2'b01;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("halt_hi", {31'd0, CPU_CLK[0]}, (k < 4) ? 32'd1 : 32'd0);
      chk("halt_halted", {31'd0, HALTED}, (k < 4) ? 32'd0 : 32'd1);
    end
    r0 = rises[0];
    r1 = rises[1];
    repeat (100) step();
    chk("halt_no_edge0", rises[0] - r0, 0);
    chk("halt_no_edge1", rises[1] - r1, 0);
    chk("halt_clk_low", {30'd0, CPU_CLK}, 32'd0);

    // Divider reload two cycles into a high half-period.
    reload_exp = 10'b1001100111;
    MODE = 2'b00;
    wait_tick0(20, "reload_wait_rise");
    for (int k = 0; k < 10; k++) begin
      step();
      chk("reload_wave", {31'd0, CPU_CLK[0]}, {31'd0, reload_exp[k]});
      DIV_WE = (k == 0) ? 2'b01 : 2'b00;
      DIV_VALUE = 16'd1;
    end
    MODE = 2'b01;
    wait_halted(20, "reload_park");

    // Longer ch0 divider so a second press lands inside STEPPING.
    DIV_WE = 2'b01;
    DIV_VALUE = 16'd7;
    step();
    DIV_WE = 2'b00;
    step();

    // Bouncy press then clean hold, then a second press while still stepping.
    MODE = 2'b10;
    t0 = ticks[0];
    t1 = ticks[1];
    a0 = acks;
    STEP_BTN = 1'b1;
    step();
    STEP_BTN = 1'b0;
    step();
    STEP_BTN = 1'b1;
    repeat (10) step();
    chk("step_busy_running", {31'd0, HALTED}, 32'd0);
    STEP_BTN = 1'b0;
    repeat (5) step();
    STEP_BTN = 1'b1;
    repeat (8) step();
    STEP_BTN = 1'b0;
    repeat (30) step();
    chk("step_ticks0", ticks[0] - t0, 1);
    chk("step_ticks1", ticks[1] - t1, 1);
    chk("step_acks", acks - a0, 1);
    chk("step_halted", {31'd0, HALTED}, 32'd1);
    chk("step_tick_bad", tick_bad, 0);

    // Reset in the middle of a step.
    STEP_BTN = 1'b1;
    wait_tick0(40, "rststep_wait_rise");
    a0 = acks;
    RST = 1'b1;
    STEP_BTN = 1'b0;
    step();
    chk("rststep_clk", {30'd0, CPU_CLK}, 32'd0);
    chk("rststep_tick", {30'd0, CPU_TICK}, 32'd0);
    chk("rststep_halted", {31'd0, HALTED}, 32'd1);
    chk("rststep_ack", {31'd0, STEP_ACK}, 32'd0);
    RST = 1'b0;
    t0 = ticks[0];
    t1 = ticks[1];
    repeat (40) step();
    chk("rststep_no_ack", acks - a0, 0);
    chk("rststep_no_tick0", ticks[0] - t0, 0);
    chk("rststep_no_tick1", ticks[1] - t1, 0);
    chk("rststep_still_halted", {31'd0, HALTED}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
